// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - shared constants and helpers for the WS2812B chain driver
// Purpose: FSM state encoding, ns-to-cycles conversion, GRB packing.
// Ports: none (package).
package ws2812b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam int PX_BITS = 24;

  // Floor of (clk_hz/1000)*ns/1e6; 64-bit so the latch time cannot overflow.
  function automatic int ns_to_cycles(input longint clk_hz, input longint ns);
    return int'((clk_hz / 64'sd1000) * ns / 64'sd1000000);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Strip wire order is G, R, B with MSB first.
  function automatic logic [23:0] pack_grb(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {g, r, b};
  endfunction

endpackage

// File: rtl/ws2812b_bit_encoder.sv
// rtl/ws2812b_bit_encoder.sv - one-bit WS2812B waveform generator
// Purpose: on i_load, drive one bit period: high T0H/T1H cycles, low for the rest of TBIT.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_load       strobe: start a new bit at this edge (only when idle or on o_bit_done)
//   i_bit        bit value sampled with i_load
//   o_data       serial waveform
//   o_bit_done   one-cycle pulse during the last cycle of the bit period
module ws2812b_bit_encoder #(
  parameter int T0H  = 20,
  parameter int T1H  = 40,
  parameter int TBIT = 62
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_bit,
  output logic o_data,
  output logic o_bit_done
);

  localparam int CNT_W = $clog2(TBIT + 1);
  localparam logic [CNT_W-1:0] TBIT_L = CNT_W'(TBIT);
  localparam logic [CNT_W-1:0] T0H_L  = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] T1H_L  = CNT_W'(T1H);

  logic             r_active;
  logic             r_bit;
  logic             r_data;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_high_len;

  assign w_high_len = r_bit ? T1H_L : T0H_L;
  // r_cnt holds the number of cycles already spent in the bit, so TBIT marks the last one.
  assign o_bit_done = r_active && (r_cnt == TBIT_L);
  assign o_data     = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_bit    <= 1'b0;
      r_data   <= 1'b0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_bit    <= i_bit;
      r_data   <= 1'b1;
      r_cnt    <= CNT_W'(1);
    end else if (r_active) begin
      if (o_bit_done) begin
        r_active <= 1'b0;
        r_data   <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_data <= (r_cnt < w_high_len);
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ws2812b_chain.sv
// rtl/ws2812b_chain.sv - WS2812B chain driver: pixel stream in, serial strip waveform out
// Purpose: accept NUM_LEDS pixels per frame, send each as 24 GRB bits, then hold the latch time.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   i_start                    frame request, sampled only in IDLE
//   i_px_valid / o_px_ready    pixel handshake (transfer = valid & ready)
//   i_red, i_green, i_blue     pixel components
//   o_busy                     frame in progress, including latch time
//   o_data                     serial line to strip DIN
//   o_underrun                 one-cycle pulse: next pixel missing at a pixel boundary
//   o_done                     one-cycle pulse in the last latch cycle
module ws2812b_chain
  import ws2812b_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int NUM_LEDS = 8,
  parameter int T0H_NS   = 400,
  parameter int T1H_NS   = 800,
  parameter int TBIT_NS  = 1250,
  parameter int TRST_NS  = 300_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_px_valid,
  output logic       o_px_ready,
  input  logic [7:0] i_red,
  input  logic [7:0] i_green,
  input  logic [7:0] i_blue,
  output logic       o_busy,
  output logic       o_data,
  output logic       o_underrun,
  output logic       o_done
);

  localparam int T0H_C  = ns_to_cycles(longint'(CLK_HZ), longint'(T0H_NS));
  localparam int T1H_C  = ns_to_cycles(longint'(CLK_HZ), longint'(T1H_NS));
  localparam int TBIT_C = ns_to_cycles(longint'(CLK_HZ), longint'(TBIT_NS));
  localparam int TRST_C = ns_to_cycles(longint'(CLK_HZ), longint'(TRST_NS));
  localparam int CNT_W  = $clog2(max_int(TBIT_C, TRST_C) + 1);
  localparam int PX_W   = $clog2(NUM_LEDS + 1);

  localparam logic [PX_W-1:0]  NUM_PX   = PX_W'(NUM_LEDS);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(TRST_C - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [23:0]      r_buf;
  logic             r_buf_full;
  logic [23:0]      r_shift;
  logic [4:0]       r_bit_idx;
  logic [PX_W-1:0]  r_px_acc;
  logic [PX_W-1:0]  r_px_sent;
  logic [CNT_W-1:0] r_lat_cnt;
  logic             r_kick;
  logic             r_underrun;

  logic w_xfer;
  logic w_load;
  logic w_enc_bit;
  logic w_bit_done;
  logic w_move;
  logic w_shift_adv;
  logic w_reload;
  logic w_to_latch;
  logic w_underrun;

  assign o_px_ready = ((r_state == ST_FETCH) || (r_state == ST_SEND)) &&
                      !r_buf_full && (r_px_acc < NUM_PX);
  assign w_xfer     = i_px_valid && o_px_ready;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_underrun = r_underrun;
  assign o_done     = (r_state == ST_LATCH) && (r_lat_cnt == LAT_LAST);

  ws2812b_bit_encoder #(
    .T0H  (T0H_C),
    .T1H  (T1H_C),
    .TBIT (TBIT_C)
  ) u_enc (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_bit      (w_enc_bit),
    .o_data     (o_data),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // The next bit is loaded in the same cycle the encoder reports bit_done,
  // so consecutive bits (and pixels) follow with no idle cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_enc_bit   = r_shift[23];
    w_move      = 1'b0;
    w_shift_adv = 1'b0;
    w_reload    = 1'b0;
    w_to_latch  = 1'b0;
    w_underrun  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (r_buf_full) begin
          w_move      = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_kick) begin
          w_load = 1'b1;
        end else if (w_bit_done) begin
          if (r_bit_idx != 5'd0) begin
            w_load      = 1'b1;
            w_enc_bit   = r_shift[22];
            w_shift_adv = 1'b1;
          end else if (r_px_sent == NUM_PX) begin
            w_to_latch  = 1'b1;
            w_state_nxt = ST_LATCH;
          end else if (r_buf_full) begin
            w_load    = 1'b1;
            w_enc_bit = r_buf[23];
            w_reload  = 1'b1;
          end else begin
            w_underrun  = 1'b1;
            w_to_latch  = 1'b1;
            w_state_nxt = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (r_lat_cnt == LAT_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_px_acc   <= '0;
      r_px_sent  <= '0;
      r_lat_cnt  <= '0;
      r_kick     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_kick     <= w_move;
      r_underrun <= w_underrun;
      if (w_xfer) begin
        r_buf      <= pack_grb(i_red, i_green, i_blue);
        r_buf_full <= 1'b1;
        r_px_acc   <= r_px_acc + PX_W'(1);
      end
      if (w_move || w_reload) begin
        r_shift    <= r_buf;
        r_buf_full <= 1'b0;
        r_bit_idx  <= 5'(PX_BITS - 1);
        r_px_sent  <= r_px_sent + PX_W'(1);
      end
      if (w_shift_adv) begin
        r_shift   <= {r_shift[22:0], 1'b0};
        r_bit_idx <= r_bit_idx - 5'd1;
      end
      if (r_state == ST_LATCH) r_lat_cnt <= r_lat_cnt + CNT_W'(1);
      // Entering LATCH discards any pixel caught at a truncating boundary and
      // clears the per-frame counters for the next frame.
      if (w_to_latch) begin
        r_lat_cnt  <= '0;
        r_buf_full <= 1'b0;
        r_px_acc   <= '0;
        r_px_sent  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812b_chain.sv
// tb/tb_ws2812b_chain.sv - self-checking bench for ws2812b_chain
module tb_ws2812b_chain;

  logic       clk;
  logic       rst;
  logic [2:0] start_v, valid_v, ready_v, data_v, busy_v, under_v, done_v;
  logic [7:0] red_v [3];
  logic [7:0] grn_v [3];
  logic [7:0] blu_v [3];

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];
  logic [7:0]  pr [8];
  logic [7:0]  pg [8];
  logic [7:0]  pb [8];

  int          sel    = 0;
  bit          mon_en = 0;
  logic        m_prev;
  int          m_hi, m_since, m_bitpos, m_bits;
  logic [23:0] m_word, m_exp;

  typedef struct {
    int s; int offer; int hold; int pulses; int xfers; int bits; int unders; int trst; int fixed;
  } vec_t;
  vec_t tv [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ws2812b_chain #(.NUM_LEDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start_v[0]), .i_px_valid(valid_v[0]),
    .o_px_ready(ready_v[0]), .i_red(red_v[0]), .i_green(grn_v[0]), .i_blue(blu_v[0]),
    .o_busy(busy_v[0]), .o_data(data_v[0]), .o_underrun(under_v[0]), .o_done(done_v[0]));

  ws2812b_chain #(.NUM_LEDS(3), .TRST_NS(20_000)) u_dut3 (
    .clk(clk), .rst(rst), .i_start(start_v[1]), .i_px_valid(valid_v[1]),
    .o_px_ready(ready_v[1]), .i_red(red_v[1]), .i_green(grn_v[1]), .i_blue(blu_v[1]),
    .o_busy(busy_v[1]), .o_data(data_v[1]), .o_underrun(under_v[1]), .o_done(done_v[1]));

  ws2812b_chain #(.NUM_LEDS(4), .TRST_NS(20_000)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(start_v[2]), .i_px_valid(valid_v[2]),
    .o_px_ready(ready_v[2]), .i_red(red_v[2]), .i_green(grn_v[2]), .i_blue(blu_v[2]),
    .o_busy(busy_v[2]), .o_data(data_v[2]), .o_underrun(under_v[2]), .o_done(done_v[2]));

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h (%0d) expected 'h%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // Decodes the wire of the selected DUT and scores pixels against exp_q.
  task automatic mon_step();
    logic d;
    logic eb;
    if (!mon_en) begin
      m_prev = 1'b0; m_hi = 0; m_since = 1000; m_bitpos = 0;
    end else begin
      d = data_v[sel];
      if (m_since < 1000) m_since++;
      if (d && !m_prev) begin
        if (m_since < 200) chk("bit_period", m_since, 62);
        m_since = 0;
        m_hi = 1;
        if (m_bitpos == 0) begin
          if (exp_q.size() == 0) begin
            chk("pixel_expected", exp_q.size(), 1);
            m_exp = 24'h0;
          end else begin
            m_exp = exp_q[0];
          end
        end
      end else if (d) begin
        m_hi++;
      end else if (m_prev) begin
        eb = m_exp[23 - m_bitpos];
        chk("high_time", m_hi, eb ? 40 : 20);
        m_word = {m_word[22:0], (m_hi > 30)};
        m_bitpos++;
        m_bits++;
        if (m_bitpos == 24) begin
          chk("pixel_grb", m_word, m_exp);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          m_bitpos = 0;
        end
      end
      m_prev = d;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_step();
    end
  end

  task automatic run_frame(input int t);
    int s, cyc, idx, xfers, unders, dones, acc_neg, rise_neg, under_neg, done_neg;
    int seen_ready, tail_busy, tail_dones, busy_at2;
    bit acc_pend, prev_d;
    s = tv[t].s;
    sel = s;
    mon_en = 1;
    m_bits = 0;
    exp_q.delete();
    // Offer changing pixels while IDLE: nothing may be accepted.
    seen_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_v[s] = 1'b1;
      red_v[s] = 8'($urandom); grn_v[s] = 8'($urandom); blu_v[s] = 8'($urandom);
      if (ready_v[s]) seen_ready++;
    end
    chk("idle_ready", seen_ready, 0);
    cyc = 0; idx = 0; xfers = 0; unders = 0; dones = 0; busy_at2 = 0;
    acc_neg = -1; rise_neg = -1; under_neg = -1; done_neg = -1;
    acc_pend = 0; prev_d = 0;
    while (dones == 0 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (data_v[s] && !prev_d && rise_neg < 0) rise_neg = cyc;
      prev_d = data_v[s];
      if (under_v[s]) begin unders++; under_neg = cyc; end
      if (done_v[s])  begin dones++;  done_neg = cyc;  end
      if (cyc == 2) busy_at2 = busy_v[s];
      if (acc_pend) begin idx++; acc_pend = 0; end
      start_v[s] = (cyc == 1) || (tv[t].pulses != 0 && dones == 0 && (cyc % 700) == 350);
      if (idx < tv[t].offer && (tv[t].hold < 0 || idx < tv[t].hold)) begin
        valid_v[s] = 1'b1;
        red_v[s] = pr[idx]; grn_v[s] = pg[idx]; blu_v[s] = pb[idx];
      end else begin
        valid_v[s] = 1'b0;
      end
      if (valid_v[s] && ready_v[s]) begin
        exp_q.push_back({pg[idx], pr[idx], pb[idx]});
        xfers++;
        acc_pend = 1;
        if (acc_neg < 0) acc_neg = cyc;
      end
    end
    start_v[s] = 1'b0;
    valid_v[s] = 1'b0;
    tail_busy = 0; tail_dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_v[s]) tail_busy++;
      if (done_v[s]) tail_dones++;
    end
    chk("done_pulses", dones, 1);
    chk("busy_after_start", busy_at2, 1);
    chk("transfers", xfers, tv[t].xfers);
    chk("bits_sent", m_bits, tv[t].bits);
    chk("underruns", unders, tv[t].unders);
    chk("first_rise_edges", rise_neg - acc_neg - 1, 2);
    chk("frame_span", done_neg - rise_neg, tv[t].bits * 62 + tv[t].trst - 1);
    if (tv[t].unders != 0) chk("underrun_at", under_neg - rise_neg, tv[t].bits * 62);
    chk("busy_after_done", tail_busy, 0);
    chk("extra_done", tail_dones, 0);
    chk("queue_drained", exp_q.size(), 0);
    mon_en = 0;
    exp_q.delete();
  endtask

  initial begin
    int n;
    tv[0] = '{s:0, offer:2, hold:-1, pulses:0, xfers:1, bits:24, unders:0, trst:15000, fixed:1};
    tv[1] = '{s:1, offer:5, hold:-1, pulses:0, xfers:3, bits:72, unders:0, trst:1000,  fixed:0};
    tv[2] = '{s:2, offer:4, hold:2,  pulses:0, xfers:2, bits:48, unders:1, trst:1000,  fixed:0};
    tv[3] = '{s:2, offer:4, hold:-1, pulses:0, xfers:4, bits:96, unders:0, trst:1000,  fixed:0};
    tv[4] = '{s:0, offer:1, hold:-1, pulses:1, xfers:1, bits:24, unders:0, trst:15000, fixed:0};

    rst = 1'b1; start_v = '0; valid_v = '0;
    for (int i = 0; i < 3; i++) begin red_v[i] = '0; grn_v[i] = '0; blu_v[i] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_outputs", {data_v, busy_v, ready_v, under_v, done_v}, 0);

    // Reset in the middle of a '1' bit: line drops at the next edge, frame abandoned.
    rst = 1'b0; sel = 0; mon_en = 0;
    @(negedge clk);
    start_v[0] = 1'b1; valid_v[0] = 1'b1;
    red_v[0] = 8'hFF; grn_v[0] = 8'h80; blu_v[0] = 8'h40;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (!data_v[0] && n < 200) begin @(negedge clk); n++; end
    chk("rst_test_rise_seen", data_v[0], 1);
    repeat (10) @(negedge clk);
    chk("pre_rst_data_high", data_v[0], 1);
    rst = 1'b1; valid_v[0] = 1'b0;
    @(negedge clk);
    chk("rst_data_low", data_v[0], 0);
    chk("rst_busy_low", busy_v[0], 0);
    rst = 1'b0;
    n = 0;
    repeat (50) begin @(negedge clk); if (done_v[0] || busy_v[0]) n++; end
    chk("rst_no_done", n, 0);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 8; i++) begin
        pr[i] = 8'($urandom); pg[i] = 8'($urandom); pb[i] = 8'($urandom);
      end
      if (tv[t].fixed != 0) begin pr[0] = 8'hFF; pg[0] = 8'h80; pb[0] = 8'h40; end
      run_frame(t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
